// File: rtl/tcam_search_engine.sv
// rtl/tcam_search_engine.sv - ternary CAM with per-bit care masks and a two-stage search pipeline
module tcam_search_engine #(
   parameter int WORD_WIDTH  = 8,
   parameter int MEMORY_SIZE = 20,
   localparam int ADDR_W     = $clog2(MEMORY_SIZE)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [WORD_WIDTH-1:0]  wr_data,
   input  logic [WORD_WIDTH-1:0]  wr_care,
   input  logic                   wr_valid,
   input  logic                   search_valid,
   input  logic [WORD_WIDTH-1:0]  search_key,
   output logic                   search_ready,
   output logic                   result_valid,
   output logic                   hit,
   output logic [ADDR_W-1:0]      hit_addr,
   output logic                   multi_hit,
   output logic [MEMORY_SIZE-1:0] match_vec
);

   logic [WORD_WIDTH-1:0]  data_q [MEMORY_SIZE];
   logic [WORD_WIDTH-1:0]  care_q [MEMORY_SIZE];
   logic [MEMORY_SIZE-1:0] valid_q;

   logic [MEMORY_SIZE-1:0] match_now;
   logic [MEMORY_SIZE-1:0] s1_match;
   logic                   s1_valid;
   logic                   search_fire;

   logic                   enc_found;
   logic                   enc_multi;
   logic [ADDR_W-1:0]      enc_addr;

   assign search_ready = ~wr_en;
   assign search_fire  = search_valid & search_ready;

   always_comb begin
      match_now = '0;
      for (int i = 0; i < MEMORY_SIZE; i++) begin
         match_now[i] = valid_q[i] && (((search_key ^ data_q[i]) & care_q[i]) == '0);
      end
   end

   // Lowest set index wins; any later set bit marks a multi-hit.
   always_comb begin
      enc_found = 1'b0;
      enc_multi = 1'b0;
      enc_addr  = '0;
      for (int i = 0; i < MEMORY_SIZE; i++) begin
         if (s1_match[i]) begin
            if (enc_found) begin
               enc_multi = 1'b1;
            end else begin
               enc_found = 1'b1;
               enc_addr  = ADDR_W'(i);
            end
         end
      end
   end

   // Out-of-range write addresses never equal any entry index, so they fall through.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < MEMORY_SIZE; i++) begin
            data_q[i] <= '0;
            care_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < MEMORY_SIZE; i++) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
               data_q[i]  <= wr_data;
               care_q[i]  <= wr_care;
               valid_q[i] <= wr_valid;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid     <= 1'b0;
         s1_match     <= '0;
         result_valid <= 1'b0;
         hit          <= 1'b0;
         hit_addr     <= '0;
         multi_hit    <= 1'b0;
         match_vec    <= '0;
      end else begin
         s1_valid     <= search_fire;
         result_valid <= s1_valid;
         if (search_fire) begin
            s1_match <= match_now;
         end
         if (s1_valid) begin
            hit       <= enc_found;
            hit_addr  <= enc_addr;
            multi_hit <= enc_multi;
            match_vec <= s1_match;
         end
      end
   end

endmodule
